// File: rtl/off_chip_link_rx.sv
// rtl/off_chip_link_rx.sv - off-chip serial link receiver: sync hunt, lock tracking, word deserializer (option: OFF_CHIP_LINK_RX_ERRCNT_EN adds err_cnt)
module off_chip_link_rx #(
    parameter int                WORD_W        = 8,
    parameter logic [WORD_W-1:0] SYNC_WORD     = WORD_W'('hB8),
    parameter int                PAYLOAD_WORDS = 4,
    parameter int                LOCK_CNT      = 2,
    parameter int                MISS_MAX      = 3
) (
    input  logic              clk160,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sdata_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              frame_start,
    output logic              locked,
    output logic              sync_err,
    output logic              overflow
`ifdef OFF_CHIP_LINK_RX_ERRCNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam int BIT_W   = $clog2(WORD_W);
    localparam int WCNT_W  = $clog2(PAYLOAD_WORDS + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_sr;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic [MATCH_W-1:0]  r_match_cnt;
    logic [MISS_W-1:0]   r_miss_cnt;
    logic                r_load_pend;
    logic                r_load_fs;
    logic [WORD_W-1:0]   r_word_out;
    logic                r_word_valid;
    logic                r_frame_start;
    logic                r_overflow;

    logic [WORD_W-1:0]   w_cand;
    logic                w_sync_hit;
    logic                w_boundary;
    logic                w_sync_slot;
    logic                w_sync_chk;
    logic                w_last_slot;
    logic                w_sync_err;
    logic                w_pay_done;
    logic                w_pay_first;
    logic                w_locked;

    // The word completing this cycle includes the bit currently on the line
    assign w_cand      = {r_sr[WORD_W-2:0], sdata_in};
    assign w_sync_hit  = (w_cand == SYNC_WORD);
    assign w_boundary  = (r_bit_cnt == BIT_W'(WORD_W - 1));
    assign w_sync_slot = (r_word_cnt == '0);
    assign w_sync_chk  = w_boundary && w_sync_slot;
    assign w_last_slot = (r_word_cnt == WCNT_W'(PAYLOAD_WORDS));

    // State register
    always_ff @(posedge clk160) begin
        if (!rst_n || !en) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: hunt for sync, verify spacing, then track misses while locked
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_HUNT: begin
                if (w_sync_hit) w_state_nxt = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (w_sync_chk) begin
                    if (!w_sync_hit) begin
                        w_state_nxt = ST_HUNT;
                    end else if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_sync_chk && !w_sync_hit && (r_miss_cnt == MISS_W'(MISS_MAX - 1))) begin
                    w_state_nxt = ST_HUNT;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // State outputs: sync_err is flagged in the cycle the bad sync word completes
    always_comb begin
        w_sync_err  = 1'b0;
        w_pay_done  = 1'b0;
        w_pay_first = 1'b0;
        w_locked    = (r_state == ST_LOCKED);
        if (en && (r_state == ST_LOCKED)) begin
            w_sync_err  = w_sync_chk && !w_sync_hit;
            w_pay_done  = w_boundary && !w_sync_slot;
            w_pay_first = (r_word_cnt == WCNT_W'(1));
        end
    end

    // Shift register and frame position counters
    always_ff @(posedge clk160) begin
        if (!rst_n || !en) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_sr <= w_cand;
            if (w_state_nxt == ST_HUNT) begin
                r_bit_cnt   <= '0;
                r_word_cnt  <= '0;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
            end else if (r_state == ST_HUNT) begin
                // Sync just found: next bit starts payload word 0 (slot 1)
                r_bit_cnt   <= '0;
                r_word_cnt  <= WCNT_W'(1);
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
            end else begin
                r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + 1'b1;
                if (w_boundary) begin
                    r_word_cnt <= w_last_slot ? '0 : r_word_cnt + 1'b1;
                end
                if (w_sync_chk) begin
                    if (r_state == ST_VERIFY) begin
                        r_match_cnt <= r_match_cnt + 1'b1;
                        r_miss_cnt  <= '0;
                    end else begin
                        r_miss_cnt  <= w_sync_hit ? '0 : r_miss_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Holding register: load one cycle after a payload word completes, drop when full
    always_ff @(posedge clk160) begin
        if (!rst_n || !en) begin
            r_load_pend   <= 1'b0;
            r_load_fs     <= 1'b0;
            r_word_out    <= '0;
            r_word_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_load_pend <= w_pay_done;
            r_load_fs   <= w_pay_first;
            if (r_load_pend) begin
                if (!r_word_valid || word_ready) begin
                    r_word_out    <= r_sr;
                    r_word_valid  <= 1'b1;
                    r_frame_start <= r_load_fs;
                end else begin
                    r_overflow    <= 1'b1;
                end
            end else if (word_ready) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign word_out    = r_word_out;
    assign word_valid  = r_word_valid;
    assign frame_start = r_frame_start;
    assign locked      = w_locked;
    assign sync_err    = w_sync_err;
    assign overflow    = r_overflow;

`ifdef OFF_CHIP_LINK_RX_ERRCNT_EN
    logic [15:0] r_err_cnt;
    logic        w_unlock;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    assign w_unlock  = en && (r_state == ST_LOCKED) && (w_state_nxt == ST_HUNT);
    assign w_err_inc = {1'b0, w_sync_err} + {1'b0, w_unlock};
    assign w_err_sum = {1'b0, r_err_cnt} + {15'b0, w_err_inc};

    // Saturating count of missed syncs and lock losses
    always_ff @(posedge clk160) begin
        if (!rst_n || !en) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_off_chip_link_rx.sv
// tb/tb_off_chip_link_rx.sv - scoreboard bench for off_chip_link_rx
module tb_off_chip_link_rx;

    logic       clk160 = 1'b0;
    logic       rst_n;
    logic       en;
    logic       sdata_in;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic       frame_start;
    logic       locked;
    logic       sync_err;
    logic       overflow;
`ifdef OFF_CHIP_LINK_RX_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    off_chip_link_rx dut (
        .clk160      (clk160),
        .rst_n       (rst_n),
        .en          (en),
        .sdata_in    (sdata_in),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err),
        .overflow    (overflow)
`ifdef OFF_CHIP_LINK_RX_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk160 = ~clk160;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic       prev_locked = 1'b0;
    logic       prev_valid  = 1'b0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         serr_q[$];
    int         lock_q[$];
    int         unlock_q[$];
    int         vrise_q[$];

    // One bit per clock; inputs change just after the edge, outputs observed at the falling edge
    task automatic tick(input logic b, input logic rdy);
        @(posedge clk160);
        #1;
        sdata_in   = b;
        word_ready = rdy;
        cyc++;
        @(negedge clk160);
        if (word_valid && word_ready) got_q.push_back({frame_start, word_out});
        if (sync_err) serr_q.push_back(cyc);
        if (locked && !prev_locked) lock_q.push_back(cyc);
        if (!locked && prev_locked) unlock_q.push_back(cyc);
        if (word_valid && !prev_valid) vrise_q.push_back(cyc);
        prev_locked = locked;
        prev_valid  = word_valid;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic rdy);
        for (int i = 7; i >= 0; i--) tick(v[i], rdy);
    endtask

    task automatic send_payload(input logic [31:0] p, input logic rdy);
        for (int k = 3; k >= 0; k--) send_byte(p[k*8 +: 8], rdy);
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [31:0] p, input logic rdy);
        send_byte(s, rdy);
        send_payload(p, rdy);
    endtask

    task automatic push_frame(input logic [31:0] p);
        exp_q.push_back({1'b1, p[31:24]});
        exp_q.push_back({1'b0, p[23:16]});
        exp_q.push_back({1'b0, p[15:8]});
        exp_q.push_back({1'b0, p[7:0]});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        rst_n = 1'b1;
        got_q.delete(); exp_q.delete(); serr_q.delete();
        lock_q.delete(); unlock_q.delete(); vrise_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; sdata_in = 1'b0; word_ready = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        checks++;
        if ({word_out, word_valid, frame_start, locked, sync_err, overflow} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {word_out, word_valid, frame_start, locked, sync_err, overflow});
        end
`ifdef OFF_CHIP_LINK_RX_ERRCNT_EN
        checks++;
        if (err_cnt !== 16'h0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
        checks++;
        if ({locked, word_valid} !== 2'b00) begin
            failures++; $display("FAIL idle_zeros got=%b exp=00", {locked, word_valid});
        end
    endtask

    task automatic test_lockup();
        int s3, p0;
        logic [8:0] g, e;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        send_frame(8'hB8, 32'h11223344, 1'b1);
        send_frame(8'hB8, 32'h11223344, 1'b1);
        checks++;
        if (got_q.size() != 0 || lock_q.size() != 0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL lockup_early words=%0d locks=%0d locked=%b exp 0/0/0", got_q.size(), lock_q.size(), locked);
        end
        push_frame(32'h11223344);
        send_byte(8'hB8, 1'b1); s3 = cyc;
        send_byte(8'h11, 1'b1); p0 = cyc;
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        checks++;
        if (lock_q.size() != 1 || lock_q[0] != s3 + 1) begin
            failures++;
            $display("FAIL lockup_lock_cycle got=%0d (n=%0d) exp=%0d", lock_q.size() > 0 ? lock_q[0] : -1, lock_q.size(), s3 + 1);
        end
        checks++;
        if (vrise_q.size() < 1 || vrise_q[0] != p0 + 2) begin
            failures++;
            $display("FAIL lockup_latency got=%0d exp=%0d", vrise_q.size() > 0 ? vrise_q[0] : -1, p0 + 2);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL lockup_word_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL lockup_word got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_false_hit();
        int s3;
        do_reset();
        send_byte(8'hB8, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b1);
        checks++;
        if (lock_q.size() != 0 || got_q.size() != 0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL false_hit_quiet locks=%0d words=%0d locked=%b exp 0/0/0", lock_q.size(), got_q.size(), locked);
        end
        send_frame(8'hB8, 32'h11223344, 1'b1);
        send_frame(8'hB8, 32'h11223344, 1'b1);
        send_byte(8'hB8, 1'b1); s3 = cyc;
        send_payload(32'h11223344, 1'b1);
        checks++;
        if (lock_q.size() != 1 || lock_q[0] != s3 + 1) begin
            failures++;
            $display("FAIL false_hit_relock got=%0d (n=%0d) exp=%0d", lock_q.size() > 0 ? lock_q[0] : -1, lock_q.size(), s3 + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [79:0] bits;
        logic        b, rdy;
        logic [8:0]  g, e;
        do_reset();
        bits = {8'hB8, 32'h11223344, 8'hB8, 32'h55667788};
        send_frame(8'hB8, 32'h11223344, 1'b1);
        send_frame(8'hB8, 32'h11223344, 1'b1);
        exp_q.push_back({1'b1, 8'h11});
        exp_q.push_back({1'b0, 8'h33});
        exp_q.push_back({1'b0, 8'h44});
        push_frame(32'h55667788);
        for (int i = 0; i < 82; i++) begin
            b   = (i < 80) ? bits[79 - i] : (i == 80);
            rdy = !(i >= 8 && i <= 27);
            tick(b, rdy);
            if (i == 16) begin
                checks++;
                if (overflow !== 1'b0) begin failures++; $display("FAIL bp_overflow_early got=%b exp=0", overflow); end
            end
            if (i >= 17 && i <= 27) begin
                checks++;
                if ({word_valid, frame_start, word_out} !== {1'b1, 1'b1, 8'h11}) begin
                    failures++;
                    $display("FAIL bp_hold_stable i=%0d got=%b%b_%h exp=11_11", i, word_valid, frame_start, word_out);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL bp_word_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL bp_word got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_loss_of_lock();
        int x4, x5, x6;
        logic [8:0] g, e;
        do_reset();
        send_frame(8'hB8, 32'h11223344, 1'b1);
        send_frame(8'hB8, 32'h11223344, 1'b1);
        push_frame(32'h11223344);
        send_frame(8'hB8, 32'h11223344, 1'b1);
        push_frame(32'hA1A2A3A4);
        send_byte(8'h00, 1'b1); x4 = cyc;
        send_payload(32'hA1A2A3A4, 1'b1);
        push_frame(32'hC1C2C3C4);
        send_byte(8'h00, 1'b1); x5 = cyc;
        send_payload(32'hC1C2C3C4, 1'b1);
        send_byte(8'h00, 1'b1); x6 = cyc;
        send_payload(32'h11223344, 1'b1);
        checks++;
        if (serr_q.size() != 3) begin
            failures++; $display("FAIL loss_sync_err_count got=%0d exp=3", serr_q.size());
        end else begin
            checks++;
            if (serr_q[0] != x4 || serr_q[1] != x5 || serr_q[2] != x6) begin
                failures++;
                $display("FAIL loss_sync_err_cycles got=%0d,%0d,%0d exp=%0d,%0d,%0d", serr_q[0], serr_q[1], serr_q[2], x4, x5, x6);
            end
        end
        checks++;
        if (unlock_q.size() != 1 || unlock_q[0] != x6 + 1) begin
            failures++;
            $display("FAIL loss_unlock_cycle got=%0d (n=%0d) exp=%0d", unlock_q.size() > 0 ? unlock_q[0] : -1, unlock_q.size(), x6 + 1);
        end
`ifdef OFF_CHIP_LINK_RX_ERRCNT_EN
        checks++;
        if (err_cnt !== 16'd4) begin failures++; $display("FAIL loss_err_cnt got=%0d exp=4", err_cnt); end
`endif
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL loss_word_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL loss_word got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_miss_recover();
        logic [7:0] syncs [6];
        syncs = '{8'h00, 8'h00, 8'hB8, 8'h00, 8'h00, 8'hB8};
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(8'hB8, 32'h11223344, 1'b1);
        for (int i = 0; i < 6; i++) send_frame(syncs[i], 32'h55667788, 1'b1);
        checks++;
        if (serr_q.size() != 4) begin failures++; $display("FAIL recover_sync_err_count got=%0d exp=4", serr_q.size()); end
        checks++;
        if (unlock_q.size() != 0 || locked !== 1'b1) begin
            failures++; $display("FAIL recover_lock_kept unlocks=%0d locked=%b exp 0/1", unlock_q.size(), locked);
        end
    endtask

    task automatic test_reset_enable();
        int s3;
        for (int m = 0; m < 2; m++) begin
            do_reset();
            send_frame(8'hB8, 32'h11223344, 1'b1);
            send_frame(8'hB8, 32'h11223344, 1'b1);
            send_frame(8'hB8, 32'h11223344, 1'b0);
            checks++;
            if ({word_valid, overflow, locked} !== 3'b111) begin
                failures++; $display("FAIL rst_en_pre mode=%0d got=%b exp=111", m, {word_valid, overflow, locked});
            end
            send_byte(8'hB8, 1'b0);
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
            if (m == 0) rst_n = 1'b0;
            else        en    = 1'b0;
            tick(1'b0, 1'b1);
            checks++;
            if ({word_out, word_valid, frame_start, locked, sync_err, overflow} !== 13'h0) begin
                failures++;
                $display("FAIL rst_en_clear mode=%0d got=%h exp=0", m, {word_out, word_valid, frame_start, locked, sync_err, overflow});
            end
            rst_n = 1'b1;
            en    = 1'b1;
            lock_q.delete();
            send_frame(8'hB8, 32'h11223344, 1'b1);
            send_frame(8'hB8, 32'h11223344, 1'b1);
            checks++;
            if (lock_q.size() != 0 || locked !== 1'b0) begin
                failures++; $display("FAIL rst_en_early_lock mode=%0d locks=%0d locked=%b exp 0/0", m, lock_q.size(), locked);
            end
            send_byte(8'hB8, 1'b1); s3 = cyc;
            send_payload(32'h11223344, 1'b1);
            checks++;
            if (lock_q.size() != 1 || lock_q[0] != s3 + 1) begin
                failures++;
                $display("FAIL rst_en_relock mode=%0d got=%0d exp=%0d", m, lock_q.size() > 0 ? lock_q[0] : -1, s3 + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lockup();
        test_false_hit();
        test_backpressure();
        test_loss_of_lock();
        test_miss_recover();
        test_reset_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
